trap_sequencer: RTL and testbench

// - Sequences machine-mode trap entry and MRET return against the CSR file's single access port (csr_address/command/write_data in, read_data/valid out).
// - Accepts one event at a time from the core (exception, interrupt or MRET) and issues the required CSR reads and writes, one per cycle.
// - Returns the redirect PC to the core fetch stage.
// - Sits between the core's commit stage and the CSR file; the core's own CSR port is muxed off while busy_o=1.
//

---
 rtl/trap_sequencer.sv | 179 +++++++++++++++++
 tb/tb_trap_sequencer.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/trap_sequencer.sv
// Machine-mode trap entry / MRET sequencer. It drives the CSR file's single access
// port one access per cycle and hands the resulting redirect PC to fetch.
module trap_sequencer #(
   parameter int MXLEN  = 64,
   parameter int CODE_W = 6
) (
   input  logic              clock_i,
   input  logic              reset_ni,
   input  logic              exception_valid_i,
   input  logic [CODE_W-1:0] exception_code_i,
   input  logic [MXLEN-1:0]  exception_pc_i,
   input  logic [MXLEN-1:0]  exception_tval_i,
   input  logic              interrupt_valid_i,
   input  logic [CODE_W-1:0] interrupt_code_i,
   input  logic [MXLEN-1:0]  interrupt_pc_i,
   input  logic              mret_valid_i,
   output logic              ready_o,
   output logic              busy_o,
   output logic [11:0]       csr_address_o,
   output logic [1:0]        csr_command_o,
   output logic [MXLEN-1:0]  csr_write_data_o,
   input  logic [MXLEN-1:0]  csr_read_data_i,
   input  logic              csr_read_data_valid_i,
   output logic              redirect_valid_o,
   output logic [MXLEN-1:0]  redirect_pc_o
);

   localparam logic [1:0]  CMD_NONE  = 2'd0;
   localparam logic [1:0]  CMD_READ  = 2'd1;
   localparam logic [1:0]  CMD_WRITE = 2'd2;
   localparam logic [11:0] A_MSTATUS = 12'h300;
   localparam logic [11:0] A_MTVEC   = 12'h305;
   localparam logic [11:0] A_MEPC    = 12'h341;
   localparam logic [11:0] A_MCAUSE  = 12'h342;
   localparam logic [11:0] A_MTVAL   = 12'h343;
   localparam logic [MXLEN-1:0] ALIGN_MASK = ~MXLEN'(3);

   typedef enum logic [3:0] {
      IDLE, RD_MSTATUS, WR_MEPC, WR_MCAUSE, WR_MTVAL, WR_MSTATUS, RD_MTVEC,
      REDIRECT, M_RD_MSTATUS, M_WR_MSTATUS, M_RD_MEPC
   } state_e;

   state_e              state_q;
   logic                ready_q, is_irq_q, redirect_valid_q;
   logic [MXLEN-1:0]    pc_q, tval_q, mstatus_q, csr_write_data_q, redirect_pc_q;
   logic [CODE_W-1:0]   code_q;
   logic [11:0]         csr_address_q;
   logic [1:0]          csr_command_q;

   logic [MXLEN-1:0]    trap_mstatus_d, mret_mstatus_d, mcause_d, vec_base_d, trap_target_d;

   always_comb begin
      trap_mstatus_d         = mstatus_q;
      trap_mstatus_d[7]      = mstatus_q[3];
      trap_mstatus_d[3]      = 1'b0;
      trap_mstatus_d[12:11]  = 2'b11;
      mret_mstatus_d         = csr_read_data_i;
      mret_mstatus_d[3]      = csr_read_data_i[7];
      mret_mstatus_d[7]      = 1'b1;
      mret_mstatus_d[12:11]  = 2'b11;
      mcause_d               = {is_irq_q, (MXLEN-1)'(code_q)};
      vec_base_d             = csr_read_data_i & ALIGN_MASK;
      // Vectored mode only offsets interrupts; exceptions always land on the base.
      if (csr_read_data_i[1:0] == 2'b01 && is_irq_q)
         trap_target_d = vec_base_d + (MXLEN'(code_q) << 2);
      else
         trap_target_d = vec_base_d;
   end

   always_ff @(posedge clock_i or negedge reset_ni) begin
      if (!reset_ni) begin
         state_q          <= IDLE;
         ready_q          <= 1'b1;
         is_irq_q         <= 1'b0;
         redirect_valid_q <= 1'b0;
         pc_q             <= '0;
         tval_q           <= '0;
         mstatus_q        <= '0;
         code_q           <= '0;
         csr_address_q    <= '0;
         csr_command_q    <= CMD_NONE;
         csr_write_data_q <= '0;
         redirect_pc_q    <= '0;
      end else begin
         redirect_valid_q <= 1'b0;
         case (state_q)
            IDLE: begin
               csr_command_q    <= CMD_NONE;
               csr_address_q    <= '0;
               csr_write_data_q <= '0;
               if (exception_valid_i || interrupt_valid_i) begin
                  pc_q          <= exception_valid_i ? exception_pc_i : interrupt_pc_i;
                  code_q        <= exception_valid_i ? exception_code_i : interrupt_code_i;
                  tval_q        <= exception_valid_i ? exception_tval_i : '0;
                  is_irq_q      <= !exception_valid_i;
                  state_q       <= RD_MSTATUS;
                  ready_q       <= 1'b0;
                  csr_command_q <= CMD_READ;
                  csr_address_q <= A_MSTATUS;
               end else if (mret_valid_i) begin
                  state_q       <= M_RD_MSTATUS;
                  ready_q       <= 1'b0;
                  csr_command_q <= CMD_READ;
                  csr_address_q <= A_MSTATUS;
               end
            end
            RD_MSTATUS: if (csr_read_data_valid_i) begin
               mstatus_q        <= csr_read_data_i;
               state_q          <= WR_MEPC;
               csr_command_q    <= CMD_WRITE;
               csr_address_q    <= A_MEPC;
               csr_write_data_q <= pc_q & ALIGN_MASK;
            end
            WR_MEPC: begin
               state_q          <= WR_MCAUSE;
               csr_address_q    <= A_MCAUSE;
               csr_write_data_q <= mcause_d;
            end
            WR_MCAUSE: begin
               state_q          <= WR_MTVAL;
               csr_address_q    <= A_MTVAL;
               csr_write_data_q <= tval_q;
            end
            WR_MTVAL: begin
               state_q          <= WR_MSTATUS;
               csr_address_q    <= A_MSTATUS;
               csr_write_data_q <= trap_mstatus_d;
            end
            WR_MSTATUS: begin
               state_q          <= RD_MTVEC;
               csr_command_q    <= CMD_READ;
               csr_address_q    <= A_MTVEC;
               csr_write_data_q <= '0;
            end
            RD_MTVEC: if (csr_read_data_valid_i) begin
               state_q          <= REDIRECT;
               csr_command_q    <= CMD_NONE;
               csr_address_q    <= '0;
               redirect_valid_q <= 1'b1;
               redirect_pc_q    <= trap_target_d;
            end
            M_RD_MSTATUS: if (csr_read_data_valid_i) begin
               state_q          <= M_WR_MSTATUS;
               csr_command_q    <= CMD_WRITE;
               csr_write_data_q <= mret_mstatus_d;
            end
            M_WR_MSTATUS: begin
               state_q          <= M_RD_MEPC;
               csr_command_q    <= CMD_READ;
               csr_address_q    <= A_MEPC;
               csr_write_data_q <= '0;
            end
            M_RD_MEPC: if (csr_read_data_valid_i) begin
               state_q          <= REDIRECT;
               csr_command_q    <= CMD_NONE;
               csr_address_q    <= '0;
               redirect_valid_q <= 1'b1;
               redirect_pc_q    <= csr_read_data_i & ALIGN_MASK;
            end
            default: begin
               state_q          <= IDLE;
               ready_q          <= 1'b1;
               csr_command_q    <= CMD_NONE;
               csr_address_q    <= '0;
               csr_write_data_q <= '0;
            end
         endcase
      end
   end

   assign ready_o          = ready_q;
   assign busy_o           = !ready_q;
   assign csr_address_o    = csr_address_q;
   assign csr_command_o    = csr_command_q;
   assign csr_write_data_o = csr_write_data_q;
   assign redirect_valid_o = redirect_valid_q;
   assign redirect_pc_o    = redirect_pc_q;

endmodule

// File: tb/tb_trap_sequencer.sv
// Bench for trap_sequencer: a CSR-file model plus an expected-access queue built
// per accepted event, compared against the DUT port every cycle.
module tb_trap_sequencer;
   localparam int MXLEN = 64, CODE_W = 6;
   localparam logic [1:0] C_NONE = 2'd0, C_RD = 2'd1, C_WR = 2'd2;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   logic              exc_v = 0, irq_v = 0, mret_v = 0, csr_valid = 1;
   logic [CODE_W-1:0] exc_code = 0, irq_code = 0;
   logic [MXLEN-1:0]  exc_pc = 0, exc_tval = 0, irq_pc = 0;
   logic              ready, busy, redir_v;
   logic [11:0]       csr_addr;
   logic [1:0]        csr_cmd;
   logic [MXLEN-1:0]  csr_wdata, csr_rdata, redir_pc;

   logic [63:0] m_status, m_epc, m_cause, m_tval, m_tvec;

   trap_sequencer #(.MXLEN(MXLEN), .CODE_W(CODE_W)) dut (
      .clock_i(clk), .reset_ni(rst_n),
      .exception_valid_i(exc_v), .exception_code_i(exc_code),
      .exception_pc_i(exc_pc), .exception_tval_i(exc_tval),
      .interrupt_valid_i(irq_v), .interrupt_code_i(irq_code), .interrupt_pc_i(irq_pc),
      .mret_valid_i(mret_v), .ready_o(ready), .busy_o(busy),
      .csr_address_o(csr_addr), .csr_command_o(csr_cmd), .csr_write_data_o(csr_wdata),
      .csr_read_data_i(csr_rdata), .csr_read_data_valid_i(csr_valid),
      .redirect_valid_o(redir_v), .redirect_pc_o(redir_pc));

   always_comb begin
      csr_rdata = '0;
      case (csr_addr)
         12'h300: csr_rdata = m_status;
         12'h305: csr_rdata = m_tvec;
         12'h341: csr_rdata = m_epc;
         12'h342: csr_rdata = m_cause;
         12'h343: csr_rdata = m_tval;
         default: csr_rdata = '0;
      endcase
   end

   typedef struct {
      logic [1:0]  cmd;
      logic [11:0] addr;
      logic [63:0] wdata;
      bit          redir;
      logic [63:0] rpc;
   } op_t;
   op_t q[$];

   int checks = 0, fails = 0, cyc = 0;
   int accept_cyc = 0, redir_cyc = -1;
   logic [63:0] exp_rpc = 0, last_rpc = 0;

   task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         fails++;
         if (fails <= 40) $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   function automatic op_t mk(logic [1:0] c, logic [11:0] a, logic [63:0] d);
      op_t o;
      o.cmd = c; o.addr = a; o.wdata = d; o.redir = 0; o.rpc = 0;
      return o;
   endfunction

   task automatic push_redirect(logic [63:0] pc);
      op_t o;
      o = mk(C_NONE, 12'h0, 64'h0);
      o.redir = 1; o.rpc = pc;
      q.push_back(o);
   endtask

   task automatic build_trap(logic [63:0] pc, logic [CODE_W-1:0] code, logic [63:0] tval, bit irq);
      logic [63:0] ms, base, tgt;
      ms = m_status;
      ms[7] = m_status[3]; ms[3] = 1'b0; ms[12:11] = 2'b11;
      base = m_tvec & ~64'd3;
      tgt = (m_tvec[1:0] == 2'b01 && irq) ? base + 64'(code) * 4 : base;
      q.push_back(mk(C_RD, 12'h300, 0));
      q.push_back(mk(C_WR, 12'h341, pc & ~64'd3));
      q.push_back(mk(C_WR, 12'h342, (irq ? 64'h8000_0000_0000_0000 : 64'h0) | 64'(code)));
      q.push_back(mk(C_WR, 12'h343, tval));
      q.push_back(mk(C_WR, 12'h300, ms));
      q.push_back(mk(C_RD, 12'h305, 0));
      push_redirect(tgt);
   endtask

   task automatic build_mret();
      logic [63:0] ms;
      ms = m_status;
      ms[3] = m_status[7]; ms[7] = 1'b1; ms[12:11] = 2'b11;
      q.push_back(mk(C_RD, 12'h300, 0));
      q.push_back(mk(C_WR, 12'h300, ms));
      q.push_back(mk(C_RD, 12'h341, 0));
      push_redirect(m_epc & ~64'd3);
   endtask

   task automatic model_write(logic [11:0] a, logic [63:0] d);
      case (a)
         12'h300: m_status = d;
         12'h341: m_epc    = d;
         12'h342: m_cause  = d;
         12'h343: m_tval   = d;
         default: ;
      endcase
   endtask

   // Mid-cycle: compare DUT outputs to the queue head, then advance the model.
   task automatic compare_cycle();
      bit idle;
      if (!rst_n) begin
         q.delete();
         exp_rpc = 0;
         chk("rst_ready", ready, 1); chk("rst_busy", busy, 0);
         chk("rst_cmd", csr_cmd, C_NONE); chk("rst_addr", csr_addr, 0);
         chk("rst_wdata", csr_wdata, 0); chk("rst_rvalid", redir_v, 0);
         chk("rst_rpc", redir_pc, 0);
         return;
      end
      idle = (q.size() == 0);
      if (!idle && q[0].redir) exp_rpc = q[0].rpc;
      chk("ready", ready, idle);
      chk("busy", busy, !idle);
      chk("cmd", csr_cmd, idle ? C_NONE : q[0].cmd);
      if (!idle && q[0].cmd != C_NONE) chk("addr", csr_addr, q[0].addr);
      chk("wdata", csr_wdata, idle ? 64'h0 : q[0].wdata);
      chk("redir_valid", redir_v, !idle && q[0].redir);
      chk("redir_pc", redir_pc, exp_rpc);
      if (redir_v) begin redir_cyc = cyc; last_rpc = redir_pc; end
      if (!idle) begin
         if (!(q[0].cmd == C_RD && !csr_valid)) begin
            if (q[0].cmd == C_WR) model_write(q[0].addr, q[0].wdata);
            void'(q.pop_front());
         end
      end else if (exc_v || irq_v || mret_v) begin
         accept_cyc = cyc;
         if (exc_v)      build_trap(exc_pc, exc_code, exc_tval, 0);
         else if (irq_v) build_trap(irq_pc, irq_code, 64'h0, 1);
         else            build_mret();
      end
   endtask

   task automatic tick();
      @(negedge clk);
      compare_cycle();
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic clear_events();
      exc_v = 0; irq_v = 0; mret_v = 0;
   endtask

   task automatic run_idle();
      int n = 0;
      while (q.size() != 0 && n < 60) begin tick(); n++; end
      tick();
      checks++;
      if (q.size() != 0) begin
         fails++;
         $display("FAIL idle_timeout: queue depth %0d expected 0", q.size());
      end
   endtask

   initial begin
      m_status = 0; m_epc = 0; m_cause = 0; m_tval = 0; m_tvec = 0;
      repeat (3) tick();
      rst_n = 1;
      tick();

      // Exception directed case
      m_tvec = 64'h8000_0000; m_status = 64'h8; m_tval = 64'h55;
      exc_v = 1; exc_code = 2; exc_pc = 64'h8000_0104; exc_tval = 64'hDEAD;
      tick(); clear_events();
      run_idle();
      chk("exc_mepc", m_epc, 64'h8000_0104);
      chk("exc_mcause", m_cause, 64'h2);
      chk("exc_mtval", m_tval, 64'hDEAD);
      chk("exc_mstatus", m_status, 64'h1880);
      chk("exc_redir_pc", last_rpc, 64'h8000_0000);
      chk("exc_latency", 64'(redir_cyc - accept_cyc), 64'd7);

      // Vectored interrupt
      m_tvec = 64'h8000_0001; m_status = 64'h8; m_tval = 64'h1234;
      irq_v = 1; irq_code = 7; irq_pc = 64'h8000_0200;
      tick(); clear_events();
      run_idle();
      chk("irq_mcause", m_cause, 64'h8000_0000_0000_0007);
      chk("irq_mtval", m_tval, 64'h0);
      chk("irq_redir_pc", last_rpc, 64'h8000_001C);

      // MRET
      m_status = 64'h1880; m_epc = 64'h8000_0107;
      mret_v = 1;
      tick(); clear_events();
      run_idle();
      chk("mret_mstatus", m_status, 64'h1888);
      chk("mret_redir_pc", last_rpc, 64'h8000_0104);
      chk("mret_latency", 64'(redir_cyc - accept_cyc), 64'd4);

      // All three at once, then an mret pulse while busy
      m_tvec = 64'h8000_0001; m_status = 64'h8;
      exc_v = 1; exc_code = 5; exc_pc = 64'h9000_0000; exc_tval = 64'h7;
      irq_v = 1; irq_code = 11; irq_pc = 64'h1000; mret_v = 1;
      tick(); clear_events();
      tick(); mret_v = 1; tick(); clear_events();
      run_idle();
      chk("prio_mcause", m_cause, 64'h5);
      chk("prio_redir_pc", last_rpc, 64'h8000_0000);
      chk("prio_latency", 64'(redir_cyc - accept_cyc), 64'd7);

      // Three stall cycles in RD_MTVEC
      exc_v = 1; exc_code = 1; exc_pc = 64'h4000; exc_tval = 64'h0;
      tick(); clear_events();
      repeat (5) tick();
      csr_valid = 0;
      repeat (3) tick();
      csr_valid = 1;
      run_idle();
      chk("stall_latency", 64'(redir_cyc - accept_cyc), 64'd10);

      // Reset landing in T3
      exc_v = 1; exc_code = 3; exc_pc = 64'h5000; exc_tval = 64'h9;
      tick(); clear_events();
      repeat (2) tick();
      rst_n = 0;
      repeat (2) tick();
      rst_n = 1;
      repeat (4) tick();

      // Randomized batches
      for (int b = 0; b < 20; b++) begin
         run_idle();
         m_status = {$urandom, $urandom};
         m_epc    = {$urandom, $urandom};
         m_tvec   = {$urandom, $urandom};
         tick();
         for (int c = 0; c < 60; c++) begin
            exc_v    = ($urandom_range(0, 7) == 0);
            irq_v    = ($urandom_range(0, 5) == 0);
            mret_v   = ($urandom_range(0, 5) == 0);
            exc_code = CODE_W'($urandom);
            irq_code = CODE_W'($urandom);
            exc_pc   = {$urandom, $urandom};
            exc_tval = {$urandom, $urandom};
            irq_pc   = {$urandom, $urandom};
            csr_valid = ($urandom_range(0, 4) != 0);
            tick();
         end
         clear_events();
         csr_valid = 1;
      end
      run_idle();

      $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
      $finish;
   end
endmodule
